// File: rtl/life_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : life_window_gen
// Description : Loads a W x H cell frame in raster order, then streams one
//               3x3 neighbourhood window per cell with valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module life_window_gen #(
    parameter int W    = 8,
    parameter int H    = 8,
    parameter int WRAP = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_cell,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       Tl,
    output logic       T,
    output logic       Tr,
    output logic       L,
    output logic       R,
    output logic       Bl,
    output logic       B,
    output logic       Br,
    output logic       C,
    output logic [3:0] out_x,
    output logic [3:0] out_y,
    output logic       out_last
);

    localparam int         c_N    = W * H;
    localparam int         c_IW   = $clog2(c_N);
    localparam logic [3:0] c_XMAX = 4'(W - 1);
    localparam logic [3:0] c_YMAX = 4'(H - 1);
    localparam logic       c_WRAP = (WRAP != 0);

    localparam logic [0:0] c_LOAD = 1'b0;
    localparam logic [0:0] c_SCAN = 1'b1;

    logic [0:0]     r_state;
    logic [c_N-1:0] r_mem;
    logic [3:0]     r_lx;
    logic [3:0]     r_ly;

    logic [c_N-1:0] w_frame;
    logic           w_in_fire;
    logic           w_out_fire;
    logic           w_load_last;
    logic           w_win_en;
    logic [3:0]     w_wx;
    logic [3:0]     w_wy;
    logic [3:0]     w_xm;
    logic [3:0]     w_xp;
    logic [3:0]     w_ym;
    logic [3:0]     w_yp;
    logic           w_xm_ok;
    logic           w_xp_ok;
    logic           w_ym_ok;
    logic           w_yp_ok;
    logic [8:0]     w_win;

    function automatic logic [c_IW-1:0] cell_idx(input logic [3:0] x, input logic [3:0] y);
        return c_IW'(y) * c_IW'(W) + c_IW'(x);
    endfunction

    function automatic logic rd(input logic [c_N-1:0] f, input logic ok,
                                input logic [3:0] x, input logic [3:0] y);
        return ok & f[cell_idx(x, y)];
    endfunction

    assign in_ready  = (r_state == c_LOAD);
    assign out_valid = (r_state == c_SCAN);

    always_comb begin
        w_in_fire   = in_valid && (r_state == c_LOAD);
        w_out_fire  = out_ready && (r_state == c_SCAN);
        w_load_last = (r_lx == c_XMAX) && (r_ly == c_YMAX);

        // Merge the cell being written so window (0,0) sees the final cell
        w_frame = r_mem;
        if (w_in_fire) begin
            w_frame[cell_idx(r_lx, r_ly)] = in_cell;
        end

        w_wx = 4'd0;
        w_wy = 4'd0;
        if (r_state == c_SCAN) begin
            if (out_x == c_XMAX) begin
                w_wy = out_y + 4'd1;
            end else begin
                w_wx = out_x + 4'd1;
                w_wy = out_y;
            end
        end
        w_win_en = (w_in_fire && w_load_last) || (w_out_fire && !out_last);
    end

    always_comb begin
        w_xm    = (w_wx == 4'd0)   ? c_XMAX : w_wx - 4'd1;
        w_xp    = (w_wx == c_XMAX) ? 4'd0   : w_wx + 4'd1;
        w_ym    = (w_wy == 4'd0)   ? c_YMAX : w_wy - 4'd1;
        w_yp    = (w_wy == c_YMAX) ? 4'd0   : w_wy + 4'd1;
        w_xm_ok = c_WRAP || (w_wx != 4'd0);
        w_xp_ok = c_WRAP || (w_wx != c_XMAX);
        w_ym_ok = c_WRAP || (w_wy != 4'd0);
        w_yp_ok = c_WRAP || (w_wy != c_YMAX);
        w_win   = {rd(w_frame, w_ym_ok & w_xm_ok, w_xm, w_ym),
                   rd(w_frame, w_ym_ok,           w_wx, w_ym),
                   rd(w_frame, w_ym_ok & w_xp_ok, w_xp, w_ym),
                   rd(w_frame, w_xm_ok,           w_xm, w_wy),
                   rd(w_frame, 1'b1,              w_wx, w_wy),
                   rd(w_frame, w_xp_ok,           w_xp, w_wy),
                   rd(w_frame, w_yp_ok & w_xm_ok, w_xm, w_yp),
                   rd(w_frame, w_yp_ok,           w_wx, w_yp),
                   rd(w_frame, w_yp_ok & w_xp_ok, w_xp, w_yp)};
    end

    always_ff @(posedge clk) begin
        r_mem <= w_frame;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_LOAD;
            r_lx     <= 4'd0;
            r_ly     <= 4'd0;
            out_x    <= 4'd0;
            out_y    <= 4'd0;
            out_last <= 1'b0;
            {Tl, T, Tr, L, C, R, Bl, B, Br} <= 9'd0;
        end else begin
            if (w_in_fire) begin
                if (r_lx == c_XMAX) begin
                    r_lx <= 4'd0;
                    r_ly <= (r_ly == c_YMAX) ? 4'd0 : r_ly + 4'd1;
                end else begin
                    r_lx <= r_lx + 4'd1;
                end
                if (w_load_last) begin
                    r_state <= c_SCAN;
                end
            end
            if (w_out_fire && out_last) begin
                r_state  <= c_LOAD;
                out_last <= 1'b0;
            end
            if (w_win_en) begin
                {Tl, T, Tr, L, C, R, Bl, B, Br} <= w_win;
                out_x    <= w_wx;
                out_y    <= w_wy;
                out_last <= (w_wx == c_XMAX) && (w_wy == c_YMAX);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_life_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_window_gen
// Description : Directed bench for life_window_gen (8x8 dead/toroidal, 5x3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_life_window_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_in_valid = 1'b0, a_in_cell = 1'b0, a_out_ready = 1'b0;
    logic b_in_valid = 1'b0, b_in_cell = 1'b0, b_out_ready = 1'b0;

    wire [2:0][8:0] win;
    wire [2:0][3:0] ox, oy;
    wire [2:0]      ov, ir, ol;

    bit         fr [0:255];
    logic [8:0] cap [0:1][0:15][0:15];
    int         checks = 0;
    int         errors = 0;

    localparam logic [19:0] c_RST_VEC = 20'h40000;

    always #5 clk = ~clk;

    life_window_gen #(.W(8), .H(8), .WRAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(ir[0]), .in_cell(a_in_cell),
        .out_valid(ov[0]), .out_ready(a_out_ready),
        .Tl(win[0][8]), .T(win[0][7]), .Tr(win[0][6]), .L(win[0][5]), .C(win[0][4]),
        .R(win[0][3]), .Bl(win[0][2]), .B(win[0][1]), .Br(win[0][0]),
        .out_x(ox[0]), .out_y(oy[0]), .out_last(ol[0]));

    life_window_gen #(.W(8), .H(8), .WRAP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(ir[1]), .in_cell(a_in_cell),
        .out_valid(ov[1]), .out_ready(a_out_ready),
        .Tl(win[1][8]), .T(win[1][7]), .Tr(win[1][6]), .L(win[1][5]), .C(win[1][4]),
        .R(win[1][3]), .Bl(win[1][2]), .B(win[1][1]), .Br(win[1][0]),
        .out_x(ox[1]), .out_y(oy[1]), .out_last(ol[1]));

    life_window_gen #(.W(5), .H(3), .WRAP(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(ir[2]), .in_cell(b_in_cell),
        .out_valid(ov[2]), .out_ready(b_out_ready),
        .Tl(win[2][8]), .T(win[2][7]), .Tr(win[2][6]), .L(win[2][5]), .C(win[2][4]),
        .R(win[2][3]), .Bl(win[2][2]), .B(win[2][1]), .Br(win[2][0]),
        .out_x(ox[2]), .out_y(oy[2]), .out_last(ol[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] pk(input int k);
        return {ov[k], ir[k], ol[k], ox[k], oy[k], win[k]};
    endfunction

    // Reference window, order {Tl,T,Tr,L,C,R,Bl,B,Br}
    function automatic logic [8:0] model(input int x, input int y, input int w, input int h, input bit wrap);
        logic [8:0] r;
        int nx, ny, b;
        b = 8;
        r = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = x + dx;
                ny = y + dy;
                if (wrap) begin
                    nx = (nx + w) % w;
                    ny = (ny + h) % h;
                end
                if (nx >= 0 && nx < w && ny >= 0 && ny < h)
                    r[b] = fr[ny * w + nx];
                b--;
            end
        end
        return r;
    endfunction

    task automatic drive(input int sel, input bit v, input bit c, input bit r);
        if (sel == 0) begin
            a_in_valid = v; a_in_cell = c; a_out_ready = r;
        end else begin
            b_in_valid = v; b_in_cell = c; b_out_ready = r;
        end
    endtask

    task automatic load(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) check("load_ready", ir[(sel == 0) ? 0 : 2], 1);
            drive(sel, 1'b1, fr[i], 1'b1);
        end
    endtask

    task automatic scan(input int sel, input int w, input int h, input bit stall);
        int ex, ey, cnt, cyc, k0, k1;
        bit rdy;
        logic [19:0] e;
        ex = 0; ey = 0; cnt = 0; cyc = 0;
        k0 = (sel == 0) ? 0 : 2;
        k1 = (sel == 0) ? 1 : 2;
        while (cnt < w * h && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            for (int k = k0; k <= k1; k++) begin
                e = {1'b1, 1'b0, 1'(ex == w - 1 && ey == h - 1), 4'(ex), 4'(ey),
                     model(ex, ey, w, h, k == 1)};
                check($sformatf("win%0d(%0d,%0d)", k, ex, ey), pk(k), e);
                if (k < 2) cap[k][ey][ex] = win[k];
            end
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            drive(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rdy);
            if (rdy) begin
                cnt++;
                if (ex == w - 1) begin ex = 0; ey++; end
                else ex++;
            end
        end
        if (cnt < w * h) check("scan_budget", cnt, w * h);
        @(negedge clk);
        for (int k = k0; k <= k1; k++) check($sformatf("done%0d", k), {ov[k], ir[k]}, 2'b01);
        drive(sel, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_frame(input int mode);
        for (int i = 0; i < 256; i++)
            fr[i] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check($sformatf("reset%0d", k), pk(k), c_RST_VEC);
        rst_n = 1'b1;

        // Blinker, dead boundary and torus
        set_frame(0);
        fr[4*8+3] = 1'b1; fr[4*8+4] = 1'b1; fr[4*8+5] = 1'b1;
        load(0, 64);
        scan(0, 8, 8, 1'b0);
        check("blk_44", cap[0][4][4], 9'b000111000);
        check("blk_43", cap[0][3][4], 9'b000000111);
        check("blk_45", cap[0][5][4], 9'b111000000);
        check("blk_00", cap[0][0][0], 9'b000000000);

        // All alive
        set_frame(1);
        load(0, 64);
        scan(0, 8, 8, 1'b0);
        check("all_00_dead", cap[0][0][0], 9'b000011011);
        check("all_33_dead", cap[0][3][3], 9'h1FF);
        check("all_00_wrap", cap[1][0][0], 9'h1FF);
        check("all_77_wrap", cap[1][7][7], 9'h1FF);

        // Only the far corner alive, stalled consumer
        set_frame(0);
        fr[63] = 1'b1;
        load(0, 64);
        scan(0, 8, 8, 1'b1);
        check("corner_00_wrap", cap[1][0][0], 9'b100000000);
        check("corner_66_wrap", cap[1][6][6], 9'b000000001);
        check("corner_00_dead", cap[0][0][0], 9'b000000000);
        check("corner_77_wrap", cap[1][7][7], 9'b000010000);

        // Abandon a partial load
        set_frame(1);
        load(0, 20);
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rst_mid_load", pk(0), c_RST_VEC);
        rst_n = 1'b1;
        set_frame(2);
        load(0, 64);
        scan(0, 8, 8, 1'b1);

        // Abandon a scan
        load(0, 64);
        repeat (10) begin
            @(negedge clk);
            drive(0, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("rst_mid_scan", pk(0), c_RST_VEC);
        check("rst_mid_scan_w", pk(1), c_RST_VEC);
        rst_n = 1'b1;

        // Small 5x3 grid
        set_frame(2);
        load(1, 15);
        scan(1, 5, 3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/life_window_gen.md
LIFE_WINDOW_GEN -- requirements
Module: life_window_gen

Interface
REQ-001 Parameter W, default 8, meaning grid width in cells; legal range 3..16.
REQ-002 Parameter H, default 8, meaning grid height in cells; legal range 3..16.
REQ-003 Parameter WRAP, default 0, meaning 0 = dead boundary and 1 = toroidal boundary.
REQ-004 Clock: clk, input, 1 bit; one clock, all logic on its rising edge.
REQ-005 Reset: rst_n, input, 1 bit; synchronous, active-low.
REQ-006 in_valid, input, 1 bit; an input cell is offered.
REQ-007 in_ready, output, 1 bit; the block accepts an input cell.
REQ-008 in_cell, input, 1 bit; cell state in raster order (x fastest), 1 = alive.
REQ-009 out_valid, output, 1 bit; a neighbourhood window is presented.
REQ-010 out_ready, input, 1 bit; the consumer accepts the window.
REQ-011 Tl, T, Tr, L, R, Bl, B, Br, outputs, 1 bit each; the eight neighbours of the centre cell (T = y-1, L = x-1).
REQ-012 C, output, 1 bit; the centre cell.
REQ-013 out_x, out_y, outputs, 4 bits each; centre coordinates.
REQ-014 out_last, output, 1 bit; the window is for (W-1, H-1).

Function
REQ-015 The block SHALL implement a two-state FSM with states LOAD and SCAN, and SHALL hold a W*H-bit frame store.
REQ-016 In LOAD, in_ready SHALL be 1; in SCAN, in_ready SHALL be 0.
REQ-017 An input transfer SHALL occur on a cycle with in_valid=1 and in_ready=1; in_cell SHALL be written at the load pointer (lx, ly), and the pointer SHALL advance in raster order.
REQ-018 On the transfer of cell (W-1, H-1), the FSM SHALL go to SCAN on the next cycle and the load pointer SHALL wrap to (0,0).
REQ-019 In SCAN, out_valid SHALL be 1, starting on the first SCAN cycle, with all window outputs registered.
REQ-020 An output transfer SHALL occur on a cycle with out_valid=1 and out_ready=1; the scan pointer SHALL then advance in raster order, and the next window SHALL appear on the following cycle.
REQ-021 With out_ready held at 1, throughput SHALL be one window per cycle, for exactly W*H windows per frame.
REQ-022 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-023 out_last SHALL be 1 only for the window with out_x=W-1 and out_y=H-1.
REQ-024 On the transfer of the last window, the FSM SHALL return to LOAD: out_valid SHALL be 0 and in_ready SHALL be 1 on the next cycle.
REQ-025 With WRAP=0, any neighbour with x<0, x>W-1, y<0 or y>H-1 SHALL read as 0.
REQ-026 With WRAP=1, neighbour coordinates SHALL wrap modulo W and H; for example, the Tl of (0,0) SHALL be (W-1, H-1).
REQ-027 Coordinate arithmetic SHALL be 4-bit and unsigned, with explicit comparisons at 0 and W-1 / H-1; no wrap shall occur through 4-bit overflow when W or H is less than 16.
REQ-028 The frame store SHALL not be cleared between frames; every cell of each frame SHALL be overwritten during LOAD.
REQ-029 In SCAN, in_valid SHALL be ignored; in LOAD, out_ready SHALL be ignored.

Reset
REQ-030 While rst_n=0 at a clock edge, the FSM SHALL go to LOAD and both pointers SHALL go to (0,0).
REQ-031 While rst_n=0 at a clock edge, out_valid, out_last, Tl..Br, C, out_x and out_y SHALL go to 0, and in_ready SHALL be 1 from the cycle after reset.
REQ-032 Reset asserted mid-LOAD or mid-SCAN SHALL abandon the frame; the next accepted cell SHALL be (0,0).
REQ-033 The frame store contents need not reset.

Verification
REQ-034 W=H=8, WRAP=0, a blinker (cells (3,4), (4,4), (5,4) alive), out_ready=1 -> 64 windows on consecutive cycles; window (4,4) has L=R=1, C=1 and the others 0; window (4,3) has Bl=B=Br=1; out_last only on (7,7).
REQ-035 W=H=8, all cells alive, WRAP=0 -> (0,0) gives R=B=Br=1 and Tl=T=Tr=L=Bl=0; (3,3) gives all eight neighbours at 1; WRAP=1 -> every window gives all nine outputs at 1.
REQ-036 Only (7,7) alive, WRAP=1 -> window (0,0) has Tl=1; window (6,6) has Br=1; with WRAP=0 both read 0.
REQ-037 Random out_ready stalls (50%) during SCAN -> outputs hold while stalled, no window is skipped or repeated, and exactly 64 transfers occur; in_ready stays 0 until the cycle after the last transfer.
REQ-038 rst_n=0 for one cycle after 20 loaded cells, then a fresh 64-cell frame -> windows reflect only the fresh frame, and the first window is at (0,0).
REQ-039 W=5, H=3 -> 15 windows; out_last at (4,2); out_x never exceeds 4.
